i2c_tx_arbiter: RTL

I2C_TX_ARBITER -- requirements
Module: i2c_tx_arbiter

---
 rtl/i2c_tx_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/i2c_tx_arbiter.sv
// rtl/i2c_tx_arbiter.sv - round-robin two-requester arbiter for an I2C transmit controller
// Optional WAIT timeout abort enabled by defining I2C_TX_TIMEOUT_EN.
module i2c_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] size0,
  input  logic [7:0] burst0,
  input  logic       req1,
  input  logic [7:0] size1,
  input  logic [7:0] burst1,
  input  logic       txStop,
  output logic       gnt0,
  output logic       gnt1,
  output logic       startTx,
  output logic [7:0] sizeSel,
  output logic [7:0] burstSel,
  output logic       busy,
  output logic       done0,
  output logic       done1,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT, DONE} state_t;

  state_t state;
  logic   last_served;
  logic   owner;
  logic   win1;

`ifdef I2C_TX_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`endif

  // On a tie the requester that was not served last wins.
  assign win1 = req1 & (~req0 | ~last_served);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      owner       <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      startTx     <= 1'b0;
      sizeSel     <= 8'd0;
      burstSel    <= 8'd0;
      busy        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err         <= 1'b0;
`ifdef I2C_TX_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      startTx <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state    <= GRANT;
            owner    <= win1;
            gnt0     <= ~win1;
            gnt1     <= win1;
            busy     <= 1'b1;
            sizeSel  <= win1 ? size1 : size0;
            burstSel <= win1 ? burst1 : burst0;
          end
        end
        GRANT: begin
          if (sizeSel != 8'd0) begin
            state   <= LAUNCH;
            startTx <= 1'b1;
          end else begin
            // Zero-length transfer completes without launching the controller.
            state <= DONE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= ~owner;
            done1 <= owner;
          end
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef I2C_TX_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (txStop) begin
            state <= DONE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= ~owner;
            done1 <= owner;
          end
`ifdef I2C_TX_TIMEOUT_EN
          else if (cnt == LIMIT) begin
            state <= DONE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= ~owner;
            done1 <= owner;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          last_served <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
